guess_grader: RTL and testbench
===============================

Name: guess_grader

Overview:
- Sequential grading engine for the Mastermind-style shape game. Sits directly downstream of the master-pattern loader.
- Consumes the stored 12-bit masterPattern and the player's 12-bit Guess, each holding four 3-bit shapes (slot 3 = bits 11:9 … slot 0 = bits 2:0).
- Produces the Znarly count (right shape, right slot) and the Zood count (right shape, wrong slot) over a fixed multi-cycle scan.
- Tracks the round count, win and game-over for the game FSM.

Parameters:
- MAX_ROUNDS, 8, number of graded guesses allowed per game (1..15).
- SHAPE_W, 3, bits per shape. Fixed at 3; present for readability only.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- startGame  input  1  synchronous new-game clear; highest priority after reset.
- masterLoaded  input  1  masterPattern is valid and stable.
- masterPattern  input  12  four 3-bit shapes.
- Guess  input  12  four 3-bit shapes.
- gradeIt  input  1  level request to grade the current Guess.
- znarlyCount  output  3  0..4, right shape in right slot.
- zoodCount  output  3  0..4, right shape in wrong slot.
- doneGrading  output  1  one-cycle pulse when counts are valid.
- invalidGuess  output  1  one-cycle pulse: request rejected because Guess held a shape 000 or 111.
- RoundNumber  output  4  graded guesses so far this game.
- gameWon  output  1  sticky; set when znarlyCount==4.
- gameOver  output  1  sticky; set on win or when RoundNumber reaches MAX_ROUNDS.

Behaviour:
- Reset (async):
  - state IDLE.
  - All outputs 0; internal capture, mask and used registers 0.
- startGame==1 at a clock edge:
  - Same clearing as reset, synchronously.
  - Aborts any grade in progress; no doneGrading pulse is produced.
- States: IDLE, ZNARLY, ZOOD, DONE, RELEASE.
- IDLE, at edge E0:
  - A request is accepted when gradeIt && masterLoaded && !gameOver.
  - Valid shapes are 001..110. If any Guess slot is 000 or 111:
    - pulse invalidGuess for one cycle and go to RELEASE;
    - RoundNumber and counts are unchanged.
  - Otherwise capture masterPattern and Guess into internal registers and go to ZNARLY.
  - Inputs are ignored after capture.
- ZNARLY (edge E1):
  - znarlyMask[i] = (m[i]==g[i]); masterUsed = znarlyMask.
  - znarlyCount = popcount(znarlyMask); zoodCount = 0; slot index k = 0.
  - Go to ZOOD.
- ZOOD (edges E2..E5, one guess slot k per cycle, k = 0..3):
  - If !znarlyMask[k], find the lowest j with !masterUsed[j] && m[j]==g[k].
  - If found: set masterUsed[j] and increment zoodCount.
  - Duplicate shapes are therefore each matched at most once.
  - At E5 (k==3):
    - RoundNumber += 1;
    - gameWon <= (znarlyCount==4);
    - gameOver <= win || (RoundNumber+1 == MAX_ROUNDS);
    - go to DONE.
- DONE (one cycle): doneGrading=1, then go to RELEASE.
  - Latency: doneGrading is high in the cycle after E5, i.e. 6 edges after acceptance.
- RELEASE:
  - Wait for gradeIt==0, then go to IDLE.
  - Holding gradeIt high yields exactly one grade.
- znarlyCount and zoodCount hold their values until the next accepted request reaches ZNARLY.
- RoundNumber saturates; it never exceeds MAX_ROUNDS.
- While gameOver==1, gradeIt is ignored until startGame.
- masterLoaded falling mid-grade does not abort the grade (captured copy is used).

Decomposition:
- Package `mastermind_pkg`:
  - shape_t (3-bit enum: 001..110 valid shapes);
  - grade_state_t;
  - constants NUM_SLOTS=4 and SHAPE_W=3;
  - function isValidShape.
- One natural sub-module: `zood_slot_matcher`.
  - Combinational priority search; inputs: the four master shapes, masterUsed, one guess shape, znarly bit.
  - Outputs: found and a one-hot j.

Test Plan:
- Exact win: master 001_010_011_100, Guess identical, gradeIt for 1 cycle -> after 6 edges doneGrading pulse, znarly=4, zood=0, RoundNumber=1, gameWon=1, gameOver=1.
- Full permutation: master 001_010_011_100, Guess 100_011_010_001 -> znarly=0, zood=4, gameWon=0.
- Duplicates:
  - master 001_010_011_100, Guess 001_001_001_001 -> znarly=1, zood=0;
  - master 001_001_010_010, Guess 010_010_001_001 -> znarly=0, zood=4.
- Invalid and held request:
  - Guess 001_000_011_100 -> invalidGuess pulse, no doneGrading, RoundNumber unchanged;
  - gradeIt held high for 20 cycles on a valid Guess -> exactly one doneGrading.
- Exhaustion: MAX_ROUNDS=8, eight non-winning grades -> RoundNumber=8, gameOver=1, ninth gradeIt ignored; startGame -> all outputs 0.
- Abort and reset:
  - startGame asserted during ZOOD -> no doneGrading, counts 0, state IDLE;
  - async reset mid-ZNARLY -> outputs 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mastermind_pkg.sv
// Shared types and helpers for the shape-game grading datapath.
// Patterns are packed as four 3-bit shapes, slot 3 in the top bits.
package mastermind_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SHAPE_W   = 3;

    typedef enum logic [2:0] {
        SHAPE_1 = 3'b001,
        SHAPE_2 = 3'b010,
        SHAPE_3 = 3'b011,
        SHAPE_4 = 3'b100,
        SHAPE_5 = 3'b101,
        SHAPE_6 = 3'b110
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ZNARLY,
        ST_ZOOD,
        ST_DONE,
        ST_RELEASE
    } grade_state_t;

    typedef logic [NUM_SLOTS-1:0][SHAPE_W-1:0] pattern_t;

    function automatic logic isValidShape(input logic [SHAPE_W-1:0] s);
        return (s != 3'b000) && (s != 3'b111);
    endfunction

    function automatic logic [2:0] popcount4(input logic [NUM_SLOTS-1:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/zood_slot_matcher.sv
// Finds the lowest unused master slot holding the given guess shape.
// Slots already matched exactly (znarly) never contribute a zood.
module zood_slot_matcher
    import mastermind_pkg::*;
(
    input  pattern_t               master_i,
    input  logic [NUM_SLOTS-1:0]   used_i,
    input  logic [SHAPE_W-1:0]     guess_i,
    input  logic                   znarly_i,
    output logic                   found_o,
    output logic [NUM_SLOTS-1:0]   onehot_o
);

    logic                 hit;
    logic [NUM_SLOTS-1:0] sel;

    always_comb begin
        hit = 1'b0;
        sel = '0;
        if (!znarly_i) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (!hit && !used_i[j] && (master_i[j] == guess_i)) begin
                    hit    = 1'b1;
                    sel[j] = 1'b1;
                end
            end
        end
    end

    assign found_o  = hit;
    assign onehot_o = sel;

endmodule

// File: rtl/guess_grader.sv
// Multi-cycle Mastermind grader: exact matches in one cycle, then one guess
// slot per cycle for wrong-slot matches; tracks rounds, win and game over.
module guess_grader
    import mastermind_pkg::*;
#(
    parameter int MAX_ROUNDS = 8,
    parameter int SHAPE_W    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        startGame,
    input  logic        masterLoaded,
    input  logic [11:0] masterPattern,
    input  logic [11:0] Guess,
    input  logic        gradeIt,
    output logic [2:0]  znarlyCount,
    output logic [2:0]  zoodCount,
    output logic        doneGrading,
    output logic        invalidGuess,
    output logic [3:0]  RoundNumber,
    output logic        gameWon,
    output logic        gameOver
);

    grade_state_t         state_q, state_d;
    pattern_t             m_q, m_d, g_q, g_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d, used_q, used_d;
    logic [1:0]           k_q, k_d;
    logic [2:0]           znarly_q, znarly_d, zood_q, zood_d;
    logic [3:0]           round_q, round_d;
    logic                 won_q, won_d, over_q, over_d, invalid_q, invalid_d;

    pattern_t             guess_p;
    logic                 guess_ok;
    logic [SHAPE_W-1:0]   guess_k;
    logic                 found;
    logic [NUM_SLOTS-1:0] found_onehot;

    assign guess_p = Guess;
    assign guess_k = g_q[k_q];

    always_comb begin
        guess_ok = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            guess_ok = guess_ok & isValidShape(guess_p[i]);
        end
    end

    zood_slot_matcher u_matcher (
        .master_i (m_q),
        .used_i   (used_q),
        .guess_i  (guess_k),
        .znarly_i (mask_q[k_q]),
        .found_o  (found),
        .onehot_o (found_onehot)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            g_q       <= '0;
            mask_q    <= '0;
            used_q    <= '0;
            k_q       <= '0;
            znarly_q  <= '0;
            zood_q    <= '0;
            round_q   <= '0;
            won_q     <= 1'b0;
            over_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            g_q       <= g_d;
            mask_q    <= mask_d;
            used_q    <= used_d;
            k_q       <= k_d;
            znarly_q  <= znarly_d;
            zood_q    <= zood_d;
            round_q   <= round_d;
            won_q     <= won_d;
            over_q    <= over_d;
            invalid_q <= invalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        g_d       = g_q;
        mask_d    = mask_q;
        used_d    = used_q;
        k_d       = k_q;
        znarly_d  = znarly_q;
        zood_d    = zood_q;
        round_d   = round_q;
        won_d     = won_q;
        over_d    = over_q;
        invalid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gradeIt && masterLoaded && !over_q) begin
                    if (guess_ok) begin
                        m_d     = masterPattern;
                        g_d     = guess_p;
                        state_d = ST_ZNARLY;
                    end else begin
                        invalid_d = 1'b1;
                        state_d   = ST_RELEASE;
                    end
                end
            end
            ST_ZNARLY: begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    mask_d[i] = (m_q[i] == g_q[i]);
                end
                used_d   = mask_d;
                znarly_d = popcount4(mask_d);
                zood_d   = '0;
                k_d      = '0;
                state_d  = ST_ZOOD;
            end
            ST_ZOOD: begin
                if (found) begin
                    used_d = used_q | found_onehot;
                    zood_d = zood_q + 3'd1;
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (round_q < 4'(MAX_ROUNDS)) begin
                        round_d = round_q + 4'd1;
                    end
                    won_d   = (znarly_q == 3'd4);
                    over_d  = won_d || ((round_q + 4'd1) == 4'(MAX_ROUNDS));
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!gradeIt) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New game wipes everything, including a grade in flight.
        if (startGame) begin
            state_d   = ST_IDLE;
            m_d       = '0;
            g_d       = '0;
            mask_d    = '0;
            used_d    = '0;
            k_d       = '0;
            znarly_d  = '0;
            zood_d    = '0;
            round_d   = '0;
            won_d     = 1'b0;
            over_d    = 1'b0;
            invalid_d = 1'b0;
        end
    end

    assign znarlyCount  = znarly_q;
    assign zoodCount    = zood_q;
    assign doneGrading  = (state_q == ST_DONE);
    assign invalidGuess = invalid_q;
    assign RoundNumber  = round_q;
    assign gameWon      = won_q;
    assign gameOver     = over_q;

endmodule

// File: tb/tb_guess_grader.sv
// Scoreboard bench for guess_grader: directed grades push expected results,
// a negedge monitor pops and compares on every doneGrading/invalidGuess.
module tb_guess_grader;

    logic        clock = 1'b0;
    logic        reset;
    logic        startGame;
    logic        masterLoaded;
    logic [11:0] masterPattern;
    logic [11:0] Guess;
    logic        gradeIt;
    logic [2:0]  znarlyCount;
    logic [2:0]  zoodCount;
    logic        doneGrading;
    logic        invalidGuess;
    logic [3:0]  RoundNumber;
    logic        gameWon;
    logic        gameOver;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         inv;
        logic [2:0] z;
        logic [2:0] zd;
        logic [3:0] rnd;
        logic       won;
        logic       over;
    } exp_t;

    exp_t expq[$];

    guess_grader #(.MAX_ROUNDS(8), .SHAPE_W(3)) dut (
        .clock         (clock),
        .reset         (reset),
        .startGame     (startGame),
        .masterLoaded  (masterLoaded),
        .masterPattern (masterPattern),
        .Guess         (Guess),
        .gradeIt       (gradeIt),
        .znarlyCount   (znarlyCount),
        .zoodCount     (zoodCount),
        .doneGrading   (doneGrading),
        .invalidGuess  (invalidGuess),
        .RoundNumber   (RoundNumber),
        .gameWon       (gameWon),
        .gameOver      (gameOver)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (doneGrading || invalidGuess)) begin
            if (expq.size() == 0) begin
                check("unexpected_pulse", {30'd0, doneGrading, invalidGuess}, 32'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("pulse_kind", {30'd0, doneGrading, invalidGuess},
                      e.inv ? 32'd1 : 32'd2);
                check("znarly", 32'(znarlyCount), 32'(e.z));
                check("zood", 32'(zoodCount), 32'(e.zd));
                check("round", 32'(RoundNumber), 32'(e.rnd));
                check("won", 32'(gameWon), 32'(e.won));
                check("over", 32'(gameOver), 32'(e.over));
            end
        end
    end

    task automatic expect_grade(input bit inv, input int z, input int zd, input int rnd,
                                input bit won, input bit over);
        exp_t e;
        e.inv = inv; e.z = 3'(z); e.zd = 3'(zd); e.rnd = 4'(rnd); e.won = won; e.over = over;
        expq.push_back(e);
    endtask

    task automatic issue(input logic [11:0] m, input logic [11:0] g, input int hold);
        @(negedge clock);
        masterLoaded  = 1'b1;
        masterPattern = m;
        Guess         = g;
        gradeIt       = 1'b1;
        repeat (hold) @(negedge clock);
        gradeIt = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (expq.size() != 0 && t < 40) begin
            @(negedge clock);
            t++;
        end
        check({name, "_drained"}, 32'(expq.size()), 32'd0);
        expq.delete();
        repeat (3) @(negedge clock);
    endtask

    task automatic new_game();
        @(negedge clock);
        startGame = 1'b1;
        @(negedge clock);
        startGame = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"},
              {18'd0, znarlyCount, zoodCount, doneGrading, invalidGuess, RoundNumber,
               gameWon, gameOver}, 32'd0);
    endtask

    localparam logic [11:0] M_A = 12'b001_010_011_100;
    localparam logic [11:0] M_B = 12'b001_001_010_010;

    initial begin
        reset = 1'b1; startGame = 1'b0; masterLoaded = 1'b0;
        masterPattern = '0; Guess = '0; gradeIt = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Exact win with explicit latency check
        expect_grade(0, 4, 0, 1, 1, 1);
        @(negedge clock);
        masterLoaded = 1'b1; masterPattern = M_A; Guess = M_A; gradeIt = 1'b1;
        @(negedge clock);
        gradeIt = 1'b0;
        check("latency_early", 32'(doneGrading), 32'd0);
        repeat (4) @(negedge clock);
        check("latency_early5", 32'(doneGrading), 32'd0);
        @(negedge clock);
        check("latency_done", 32'(doneGrading), 32'd1);
        drain("win");
        issue(M_A, M_A, 1);      // ignored: game over
        drain("after_win");

        new_game();
        check_all_zero("start1");
        expect_grade(0, 0, 4, 1, 0, 0);
        issue(M_A, 12'b100_011_010_001, 1);
        drain("perm");
        expect_grade(0, 1, 0, 2, 0, 0);
        issue(M_A, 12'b001_001_001_001, 1);
        drain("dup1");
        expect_grade(0, 0, 4, 3, 0, 0);
        issue(M_B, 12'b010_010_001_001, 1);
        drain("dup2");
        expect_grade(1, 0, 4, 3, 0, 0);
        issue(M_B, 12'b001_000_011_100, 1);
        drain("invalid");
        expect_grade(0, 1, 1, 4, 0, 0);
        issue(M_B, 12'b010_001_100_011, 20);
        drain("held");
        for (int r = 5; r <= 8; r++) begin
            expect_grade(0, 0, 4, r, 0, (r == 8));
            issue(M_B, 12'b010_010_001_001, 1);
            drain("exhaust");
        end
        issue(M_B, 12'b010_010_001_001, 1);   // ninth, ignored
        drain("ninth");
        check("exhaust_round", 32'(RoundNumber), 32'd8);
        check("exhaust_over", 32'(gameOver), 32'd1);
        new_game();
        check_all_zero("start2");

        // Abort during ZOOD
        issue(M_A, M_A, 1);
        @(negedge clock);
        check("abort_pre_znarly", 32'(znarlyCount), 32'd4);
        startGame = 1'b1;
        @(negedge clock);
        startGame = 1'b0;
        check_all_zero("abort");
        repeat (10) @(negedge clock);
        expect_grade(0, 0, 4, 1, 0, 0);
        issue(M_A, 12'b100_011_010_001, 1);
        drain("post_abort");

        // Async reset while in ZNARLY
        issue(M_A, M_A, 1);
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("final_queue", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
